// File: rtl/stump_mem_arbiter.sv
// ============================================================================
// Module  : stump_mem_arbiter
// Purpose : Shares the single Stump memory port between the CPU sequencer
//           (port 0) and a DMA/debug master (port 1). The winner's access is
//           registered onto the memory bus. The arbiter then waits for
//           mem_rdy_i, or gives up after TIMEOUT cycles, and returns a
//           one-cycle acknowledge carrying the read data or an error flag.
//           The CPU has fixed priority. After MAX_STARVE lost arbitrations in
//           a row, the DMA port wins the next contested grant.
// Ports   : clk, rst_n            - clock, async active-low reset
//           cpu_*_i / cpu_ack_o   - port 0 request/qualifiers and ack pulse
//           dma_*_i / dma_ack_o   - port 1 request/qualifiers and ack pulse
//           rdata_o, err_o        - response data / timeout flag (with an ack)
//           owner_o               - current or last granted port (1 = DMA)
//           mem_*_o / mem_*_i     - registered memory bus and its responses
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module stump_mem_arbiter #(
  parameter int TIMEOUT    = 15,
  parameter int MAX_STARVE = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cpu_req_i,
  input  logic        cpu_we_i,
  input  logic [15:0] cpu_addr_i,
  input  logic [15:0] cpu_wdata_i,
  output logic        cpu_ack_o,
  input  logic        dma_req_i,
  input  logic        dma_we_i,
  input  logic [15:0] dma_addr_i,
  input  logic [15:0] dma_wdata_i,
  output logic        dma_ack_o,
  output logic [15:0] rdata_o,
  output logic        err_o,
  output logic        owner_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [15:0] mem_addr_o,
  output logic [15:0] mem_wdata_o,
  input  logic [15:0] mem_rdata_i,
  input  logic        mem_rdy_i
);

  localparam int WAIT_W   = (TIMEOUT    > 1) ? $clog2(TIMEOUT)        : 1;
  localparam int STARVE_W = $clog2(MAX_STARVE + 1);
  localparam logic [WAIT_W-1:0]   WAIT_LAST  = WAIT_W'(TIMEOUT - 1);
  localparam logic [STARVE_W-1:0] STARVE_MAX = STARVE_W'(MAX_STARVE);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t              state_q,   state_d;
  logic [WAIT_W-1:0]   wait_q,    wait_d;
  logic [STARVE_W-1:0] starve_q,  starve_d;
  logic                cpu_ack_q, cpu_ack_d;
  logic                dma_ack_q, dma_ack_d;
  logic [15:0]         rdata_q,   rdata_d;
  logic                err_q,     err_d;
  logic                owner_q,   owner_d;
  logic                mem_req_q, mem_req_d;
  logic                mem_we_q,  mem_we_d;
  logic [15:0]         mem_addr_q,  mem_addr_d;
  logic [15:0]         mem_wdata_q, mem_wdata_d;

  logic grant_dma;

  // DMA wins when it is the only requester, or when the CPU has beaten it
  // MAX_STARVE times in a row.
  assign grant_dma = dma_req_i & (~cpu_req_i | (starve_q == STARVE_MAX));

  always_comb begin
    state_d     = state_q;
    wait_d      = wait_q;
    starve_d    = starve_q;
    cpu_ack_d   = cpu_ack_q;
    dma_ack_d   = dma_ack_q;
    rdata_d     = rdata_q;
    err_d       = err_q;
    owner_d     = owner_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;

    case (state_q)
      IDLE: begin
        if (cpu_req_i || dma_req_i) begin
          owner_d     = grant_dma;
          mem_req_d   = 1'b1;
          mem_we_d    = grant_dma ? dma_we_i    : cpu_we_i;
          mem_addr_d  = grant_dma ? dma_addr_i  : cpu_addr_i;
          mem_wdata_d = grant_dma ? dma_wdata_i : cpu_wdata_i;
          wait_d      = '0;
          state_d     = ACCESS;
          if (grant_dma) begin
            starve_d = '0;
          end else if (dma_req_i && (starve_q != STARVE_MAX)) begin
            starve_d = starve_q + 1'b1;
          end
        end
      end

      ACCESS: begin
        // A ready in the last allowed cycle still counts as a normal
        // completion, so mem_rdy_i is tested ahead of the timeout.
        if (mem_rdy_i || (wait_q == WAIT_LAST)) begin
          state_d     = RESP;
          cpu_ack_d   = ~owner_q;
          dma_ack_d   = owner_q;
          err_d       = ~mem_rdy_i;
          rdata_d     = (mem_rdy_i && !mem_we_q) ? mem_rdata_i : 16'h0000;
          mem_req_d   = 1'b0;
          mem_we_d    = 1'b0;
          mem_addr_d  = 16'h0000;
          mem_wdata_d = 16'h0000;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end

      RESP: begin
        cpu_ack_d = 1'b0;
        dma_ack_d = 1'b0;
        rdata_d   = 16'h0000;
        err_d     = 1'b0;
        state_d   = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      wait_q      <= '0;
      starve_q    <= '0;
      cpu_ack_q   <= 1'b0;
      dma_ack_q   <= 1'b0;
      rdata_q     <= 16'h0000;
      err_q       <= 1'b0;
      owner_q     <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= 16'h0000;
      mem_wdata_q <= 16'h0000;
    end else begin
      state_q     <= state_d;
      wait_q      <= wait_d;
      starve_q    <= starve_d;
      cpu_ack_q   <= cpu_ack_d;
      dma_ack_q   <= dma_ack_d;
      rdata_q     <= rdata_d;
      err_q       <= err_d;
      owner_q     <= owner_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  assign cpu_ack_o   = cpu_ack_q;
  assign dma_ack_o   = dma_ack_q;
  assign rdata_o     = rdata_q;
  assign err_o       = err_q;
  assign owner_o     = owner_q;
  assign mem_req_o   = mem_req_q;
  assign mem_we_o    = mem_we_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_wdata_o = mem_wdata_q;

endmodule

`default_nettype wire

// File: tb/tb_stump_mem_arbiter.sv
// ============================================================================
// Module  : tb_stump_mem_arbiter
// Purpose : Self-checking bench for stump_mem_arbiter. Single-port accesses
//           are listed as a vector table. Hand-written sequences cover
//           starvation ordering and asynchronous reset during an access.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_stump_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cpu_req = 1'b0, cpu_we = 1'b0;
  logic [15:0] cpu_addr = 16'h0, cpu_wdata = 16'h0;
  logic        cpu_ack;
  logic        dma_req = 1'b0, dma_we = 1'b0;
  logic [15:0] dma_addr = 16'h0, dma_wdata = 16'h0;
  logic        dma_ack;
  logic [15:0] rdata;
  logic        err, owner;
  logic        mem_req, mem_we;
  logic [15:0] mem_addr, mem_wdata;
  logic [15:0] mem_rdata = 16'h0;
  logic        mem_rdy = 1'b0;

  int checks = 0;
  int errors = 0;

  // Memory model: assert ready when rdy_delay mem_req cycles have elapsed.
  int          rdy_delay = 0;
  int          acc_cnt   = 0;
  logic [15:0] rd_val    = 16'h0;

  always #5 clk = ~clk;

  stump_mem_arbiter #(.TIMEOUT(15), .MAX_STARVE(3)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cpu_req_i  (cpu_req),
    .cpu_we_i   (cpu_we),
    .cpu_addr_i (cpu_addr),
    .cpu_wdata_i(cpu_wdata),
    .cpu_ack_o  (cpu_ack),
    .dma_req_i  (dma_req),
    .dma_we_i   (dma_we),
    .dma_addr_i (dma_addr),
    .dma_wdata_i(dma_wdata),
    .dma_ack_o  (dma_ack),
    .rdata_o    (rdata),
    .err_o      (err),
    .owner_o    (owner),
    .mem_req_o  (mem_req),
    .mem_we_o   (mem_we),
    .mem_addr_o (mem_addr),
    .mem_wdata_o(mem_wdata),
    .mem_rdata_i(mem_rdata),
    .mem_rdy_i  (mem_rdy)
  );

  typedef struct {
    logic        cpu_req;
    logic        cpu_we;
    logic [15:0] cpu_addr;
    logic [15:0] cpu_wdata;
    logic        dma_req;
    logic        dma_we;
    logic [15:0] dma_addr;
    logic [15:0] dma_wdata;
    int          rdy_delay;
    logic [15:0] mrdata;
    logic        exp_owner;
    logic        exp_we;
    logic [15:0] exp_addr;
    logic [15:0] exp_wdata;
    logic [15:0] exp_rdata;
    logic        exp_err;
    int          exp_cycles;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Advance one cycle and sample 1 ns after the rising edge; the memory
  // model then reacts to the mem_req value of the cycle just started.
  task automatic tick();
    @(posedge clk);
    #1;
    if (mem_req) begin
      mem_rdy   = (acc_cnt == rdy_delay);
      mem_rdata = rd_val;
      acc_cnt++;
    end else begin
      mem_rdy = 1'b0;
      acc_cnt = 0;
    end
  endtask

  task automatic run_vec(input int idx);
    vec_t v;
    int   cycles;
    int   bus_bad;
    bit   got;
    v = vecs[idx];
    cpu_req = v.cpu_req;  cpu_we = v.cpu_we;  cpu_addr = v.cpu_addr;  cpu_wdata = v.cpu_wdata;
    dma_req = v.dma_req;  dma_we = v.dma_we;  dma_addr = v.dma_addr;  dma_wdata = v.dma_wdata;
    rdy_delay = v.rdy_delay;
    rd_val    = v.mrdata;
    cycles = 0; bus_bad = 0; got = 0;
    for (int c = 0; c < 40 && !got; c++) begin
      tick();
      if (mem_req) begin
        cycles++;
        if (mem_we !== v.exp_we || mem_addr !== v.exp_addr || mem_wdata !== v.exp_wdata)
          bus_bad++;
        // Qualifiers changed mid-access must not reach the bus.
        cpu_we = ~v.cpu_we;  cpu_addr = ~v.cpu_addr;  cpu_wdata = ~v.cpu_wdata;
        dma_we = ~v.dma_we;  dma_addr = ~v.dma_addr;  dma_wdata = ~v.dma_wdata;
      end
      if (cpu_ack || dma_ack) begin
        got = 1;
        chk($sformatf("v%0d cpu_ack", idx), cpu_ack, !v.exp_owner);
        chk($sformatf("v%0d dma_ack", idx), dma_ack, v.exp_owner);
        chk($sformatf("v%0d rdata", idx), rdata, v.exp_rdata);
        chk($sformatf("v%0d err", idx), err, v.exp_err);
        chk($sformatf("v%0d owner", idx), owner, v.exp_owner);
        cpu_req = 1'b0;
        dma_req = 1'b0;
      end
    end
    chk($sformatf("v%0d ack_seen", idx), got, 1'b1);
    chk($sformatf("v%0d req_cycles", idx), cycles, v.exp_cycles);
    chk($sformatf("v%0d bus_stable", idx), bus_bad, 0);
    tick();
    chk($sformatf("v%0d idle_acks", idx), {cpu_ack, dma_ack}, 2'b00);
    chk($sformatf("v%0d idle_rdata_err", idx), {rdata, err}, 17'h0);
    chk($sformatf("v%0d idle_owner_held", idx), owner, v.exp_owner);
  endtask

  initial begin
    int          n;
    int          last;
    logic [7:0]  ord;
    bit          got;

    //            creq cwe caddr     cwdata    dreq dwe daddr     dwdata    dly mrdata    own we addr      wdata     rdata     err cyc
    vecs[0] = '{1'b1, 1'b0, 16'h0040, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000, 0,  16'hBEEF, 1'b0, 1'b0, 16'h0040, 16'h0000, 16'hBEEF, 1'b0, 1};
    vecs[1] = '{1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b1, 16'h1234, 16'h00AA, 3,  16'h5555, 1'b1, 1'b1, 16'h1234, 16'h00AA, 16'h0000, 1'b0, 4};
    vecs[2] = '{1'b1, 1'b0, 16'h0100, 16'h3333, 1'b0, 1'b0, 16'h0000, 16'h0000, 99, 16'hDEAD, 1'b0, 1'b0, 16'h0100, 16'h3333, 16'h0000, 1'b1, 15};
    vecs[3] = '{1'b1, 1'b0, 16'h0200, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000, 14, 16'h7E57, 1'b0, 1'b0, 16'h0200, 16'h0000, 16'h7E57, 1'b0, 15};
    vecs[4] = '{1'b1, 1'b1, 16'hFFFF, 16'hA5A5, 1'b0, 1'b0, 16'h0000, 16'h0000, 1,  16'h1111, 1'b0, 1'b1, 16'hFFFF, 16'hA5A5, 16'h0000, 1'b0, 2};
    vecs[5] = '{1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0, 16'h0001, 16'h0000, 0,  16'h1357, 1'b1, 1'b0, 16'h0001, 16'h0000, 16'h1357, 1'b0, 1};

    // Reset state: every output low while rst_n is held.
    #2;
    chk("rst_mem_bus", {mem_req, mem_we, mem_addr, mem_wdata}, 34'h0);
    chk("rst_acks_owner", {cpu_ack, dma_ack, owner}, 3'b000);
    chk("rst_rdata_err", {rdata, err}, 17'h0);
    #10 rst_n = 1'b1;
    tick();

    for (int i = 0; i < 6; i++) run_vec(i);

    // Starvation: both ports held, zero wait states.
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0C0C;
    dma_req = 1'b1; dma_we = 1'b0; dma_addr = 16'hD0D0;
    rdy_delay = 0; rd_val = 16'h4242;
    ord = 8'b1000_1000;
    n = 0; last = 0;
    for (int c = 0; c < 60 && n < 8; c++) begin
      tick();
      if (cpu_ack || dma_ack) begin
        chk($sformatf("starve_order%0d", n), {cpu_ack, dma_ack}, {~ord[n], ord[n]});
        if (n > 0) chk($sformatf("starve_gap%0d", n), c - last, 3);
        last = c;
        n++;
        if (n == 8) begin
          cpu_req = 1'b0;
          dma_req = 1'b0;
        end
      end
    end
    chk("starve_ack_count", n, 8);
    tick();

    // Reset while the third contested CPU access is pending. The starve
    // count is at its limit then, so a surviving count would hand the
    // next contested grant to the DMA port.
    cpu_req = 1'b1; dma_req = 1'b1; rdy_delay = 0;
    n = 0;
    for (int c = 0; c < 30 && n < 2; c++) begin
      tick();
      if (cpu_ack || dma_ack) n++;
    end
    chk("pre_reset_acks", n, 2);
    rdy_delay = 99;
    tick(); tick(); tick();
    chk("pre_reset_busy", {mem_req, owner, mem_addr}, {1'b1, 1'b0, 16'h0C0C});
    #3 rst_n = 1'b0;
    #1;
    chk("async_rst_bus", {mem_req, mem_addr}, 17'h0);
    chk("async_rst_acks", {cpu_ack, dma_ack}, 2'b00);
    #2 rst_n = 1'b1;
    rdy_delay = 0;
    got = 0;
    for (int c = 0; c < 20 && !got; c++) begin
      tick();
      if (cpu_ack || dma_ack) begin
        got = 1;
        chk("post_reset_winner", {cpu_ack, dma_ack}, 2'b10);
        cpu_req = 1'b0;
        dma_req = 1'b0;
      end
    end
    chk("post_reset_ack_seen", got, 1'b1);
    tick();

    // Reset during a DMA access: owner and the bus must drop without a clock.
    dma_req = 1'b1; dma_we = 1'b1; dma_addr = 16'h4321; dma_wdata = 16'h0F0F;
    rdy_delay = 99;
    tick(); tick(); tick();
    chk("dma_busy", {mem_req, mem_we, owner}, 3'b111);
    #3 rst_n = 1'b0;
    #1;
    chk("async_rst_owner", owner, 1'b0);
    chk("async_rst_dma", {mem_req, mem_we, dma_ack}, 3'b000);
    #2 rst_n = 1'b1;
    dma_req = 1'b0;
    tick();
    run_vec(0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/stump_mem_arbiter.md
Name: stump_mem_arbiter

Overview:
Arbitrates the single Stump memory port between two requesters: port 0 (CPU fetch and LDST traffic from the FETCH/EXECUTE/MEMORY sequencer) and port 1 (DMA/debug master).
- Registers the winner's address, data and direction onto the memory bus and waits for memory ready, with a timeout.
- Returns a one-cycle acknowledge with read data or an error.
- Fixed CPU priority with a bounded starvation guarantee for port 1.

Parameters:
TIMEOUT, 15, maximum ACCESS cycles waiting for mem_rdy before aborting (≥1).
MAX_STARVE, 3, consecutive lost arbitrations after which port 1 wins over port 0 (≥1).

Ports:
clk  in  1  system clock, all state changes on rising edge
rst_n  in  1  master reset, asynchronous, active-low
cpu_req  in  1  port 0 request, held with its qualifiers until cpu_ack
cpu_we  in  1  port 0 write (1) / read (0)
cpu_addr  in  16  port 0 word address
cpu_wdata  in  16  port 0 write data
cpu_ack  out  1  port 0 completion pulse, one cycle
dma_req  in  1  port 1 request, held with its qualifiers until dma_ack
dma_we  in  1  port 1 write (1) / read (0)
dma_addr  in  16  port 1 word address
dma_wdata  in  16  port 1 write data
dma_ack  out  1  port 1 completion pulse, one cycle
rdata  out  16  read data, valid only in a cycle where cpu_ack or dma_ack = 1
err  out  1  timeout flag, valid only with an ack
owner  out  1  current/last granted port (0 = CPU, 1 = DMA)
mem_req  out  1  memory access strobe
mem_we  out  1  memory write enable
mem_addr  out  16  memory address
mem_wdata  out  16  memory write data
mem_rdata  in  16  memory read data, valid when mem_rdy = 1
mem_rdy  in  1  memory completion, may be asserted in the first mem_req cycle

Behaviour:
- Reset (rst_n = 0, asynchronous): all outputs go to 0 immediately. State = IDLE, wait counter = 0, starve counter = 0. An in-flight access is dropped and no ack is issued.
- FSM states are IDLE, ACCESS and RESP. All outputs are registered.
- IDLE: requests are sampled only in this state.
  - Only one port requesting: that port wins.
  - Both requesting: port 1 wins if starve == MAX_STARVE, else port 0 wins.
  - On a grant: latch owner, and load mem_we/mem_addr/mem_wdata from the winner. Set mem_req = 1, clear the wait counter, go to ACCESS.
  - No request: stay in IDLE, mem_req = 0.
- Starve counter:
  - Increments (saturating at MAX_STARVE) when both ports request and port 0 wins.
  - Clears when port 1 is granted.
  - Unchanged otherwise.
- ACCESS: mem_req and the latched bus values are held stable.
  - mem_rdy = 1: rdata <= mem_rdata for reads (16'h0000 for writes), err <= 0, go to RESP.
  - mem_rdy = 0 and wait == TIMEOUT-1: rdata <= 16'h0000, err <= 1, go to RESP.
  - Otherwise: wait <= wait + 1.
  - mem_rdy in the final allowed cycle completes normally; it wins over the timeout.
- Leaving ACCESS: mem_req, mem_we, mem_addr and mem_wdata return to 0 on the transition to RESP.
- RESP (one cycle): ack for the owner = 1; the other ack stays 0; rdata/err are held. Next state is IDLE, where ack, rdata and err clear to 0.
- Latency: request seen in IDLE cycle N gives mem_req in N+1, ack in N+2 (with mem_rdy in N+1), and IDLE again in N+3. Minimum 3 cycles per access; back-to-back requests are granted in N+3.
- Handshake: a requester drops req during its ack cycle. req still high in the following IDLE cycle is a new request.
- Simultaneous requests: exactly one grant per IDLE cycle. The loser keeps req asserted and is re-arbitrated in the next IDLE.
- Lockout: the requester qualifiers are ignored outside IDLE. Changing them mid-access has no effect.
- owner holds its value after RESP until the next grant.

Test Plan:
- Single CPU read: cpu_req = 1, cpu_addr = 16'h0040, mem_rdy = 1 in the first ACCESS cycle with mem_rdata = 16'hBEEF -> mem_req high for 1 cycle with mem_addr = 16'h0040; cpu_ack one cycle later with rdata = 16'hBEEF, err = 0; dma_ack = 0.
- DMA write with wait states: dma_we = 1, dma_addr = 16'h1234, dma_wdata = 16'h00AA, mem_rdy after 3 cycles -> mem_req/mem_we/mem_wdata stable for 4 cycles; dma_ack next cycle with rdata = 16'h0000; owner = 1.
- Starvation: both requests held continuously with MAX_STARVE = 3 -> grant order CPU, CPU, CPU, DMA, CPU, CPU, CPU, DMA; acks spaced 3 cycles apart.
- Timeout: CPU read, mem_rdy never asserted, TIMEOUT = 15 -> mem_req high exactly 15 cycles, then cpu_ack = 1, err = 1, rdata = 16'h0000; next grant proceeds normally.
- Reset mid-access: assert rst_n = 0 during ACCESS -> mem_req, acks and owner drop to 0 immediately without a clock edge; after release, a CPU request is granted from IDLE with starve = 0.
- Edge timeout: mem_rdy = 1 exactly in ACCESS cycle 15 -> normal completion, err = 0, rdata = mem_rdata.
